data_memory_ctrl: RTL

Parametrised data-memory block for the MIPS CPU datapath. It is a single-port word RAM with per-byte write enables and a valid/ready request handshake. Reads return on a registered, one-cycle-latency response. A sequential clear engine zeroes the array after reset and on command. The CPU's MEM stage uses it in place of the fixed 8-bit data memory.

---
 rtl/data_memory_ctrl_pkg.sv | 20 ++
 rtl/data_memory_ctrl_if.sv | 28 ++
 rtl/data_memory_ctrl_ram.sv | 48 ++++
 rtl/data_memory_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and helpers for the data-memory controller: FSM state
// encoding, byte-lane count and parameter sanity checks.
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } mem_state_e;

    // Number of byte lanes in a word of the given width.
    function automatic int lanes_f(input int data_w);
        return data_w / 8;
    endfunction

    // True when the width is byte-aligned and the depth fits the address space.
    function automatic bit cfg_ok_f(input int data_w, input int addr_w, input int depth);
        return ((data_w % 8) == 0) && (depth >= 1) && (depth <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the CPU MEM stage (master) and the data
// memory (slave).
interface data_memory_ctrl_if
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_we;
    logic [ADDR_W-1:0]            req_addr;
    logic [DATA_W-1:0]            req_wdata;
    logic [lanes_f(DATA_W)-1:0]   req_be;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_ctrl_ram.sv
// Single-port word RAM with byte-masked synchronous write and a registered
// read port. The array itself has no reset; only the read register does.
module data_ram_sp
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_we,
    input  logic                       i_re,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [lanes_f(DATA_W)-1:0] i_be,
    output logic [DATA_W-1:0]          o_rdata
);
    localparam int LANES = lanes_f(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Byte-masked write: only enabled lanes of the addressed word change.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_be[k]) begin
                    r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    // Registered read; the output holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data-memory controller: clear-engine FSM, request port muxing in front of
// the RAM and the read response / range-error flags.
module data_memory_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    output logic              busy,
    data_memory_ctrl_if.slave bus
);
    localparam int LANES = lanes_f(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (!cfg_ok_f(DATA_W, ADDR_W, DEPTH)) begin : g_cfg_bad
        $error("data_memory_ctrl: DATA_W must be a multiple of 8 and DEPTH <= 2**ADDR_W");
    end

    mem_state_e        r_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_busy;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_oor;

    logic              w_in_range;
    logic              w_ready;
    logic              w_accept;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [LANES-1:0]  w_ram_be;
    logic [DATA_W-1:0] w_ram_rdata;

    // A pending clear blocks the request port in the same cycle.
    assign w_in_range = ({1'b0, bus.req_addr} < (ADDR_W+1)'(DEPTH));
    assign w_ready    = (r_state == IDLE) && !clear;
    assign w_accept   = bus.req_valid && w_ready;

    // RAM port mux: the clear engine owns the RAM while it runs.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = bus.req_addr;
        w_ram_wdata = bus.req_wdata;
        w_ram_be    = bus.req_be;
        if (r_state == CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_addr  = r_clr_addr;
            w_ram_wdata = '0;
            w_ram_be    = '1;
        end else begin
            w_ram_we = w_accept && bus.req_we && w_in_range;
            w_ram_re = w_accept && !bus.req_we && w_in_range;
        end
    end

    // FSM, clear counter and response flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= CLEAR;
            r_clr_addr  <= '0;
            r_busy      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_oor       <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        r_state     <= CLEAR;
                        r_clr_addr  <= '0;
                        r_busy      <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                    end else if (w_accept && !bus.req_we) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= !w_in_range;
                        r_oor       <= !w_in_range;
                    end else begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= CLEAR;
                    r_clr_addr  <= '0;
                    r_busy      <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    data_ram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .i_be    (w_ram_be),
        .o_rdata (w_ram_rdata)
    );

    assign busy          = r_busy;
    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_oor ? '0 : w_ram_rdata;

endmodule
